// File: rtl/uart_rx.sv
// uart_rx - oversampling UART receiver (8 data bits, LSB first, 1 stop bit).
//
// The rx pin is synchronised, the receiver aligns to the start bit and takes
// 16 samples per bit. Each bit is the majority of samples 7/8/9, resolved on
// sample 9. Good bytes are presented with a one-cycle rx_ready strobe. A low
// stop bit gives a one-cycle frame_err strobe and the byte is discarded.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : one even-parity bit between data and stop. A mismatch gives a
//               one-cycle parity_err strobe in place of rx_ready.
//   undefined : 10-bit frame, parity_err tied low.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line rate in bit/s
// Ports:
//   clk         system clock, rising edge
//   n_reset     asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   rx_ready    one-cycle strobe, rx_data holds a new good byte
//   rx_data     last good byte, stable until the next rx_ready
//   rx_busy     high while a frame is being received
//   frame_err   one-cycle strobe, stop bit sampled low
//   parity_err  one-cycle strobe, parity mismatch (0 without parity)

module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int CW  = $clog2(DIV) + 1;

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_rx: CLK_HZ too low for BAUD (DIV < 1)");
        end
    endgenerate

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    smp;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          s7, s8;

    // Two synchronising flops plus the edge-detect flop, all resetting high
    // so that reset itself never looks like a falling edge.
    logic       rx_s1, rxs, rxs_d;
    // Marks when the sync chain holds real line samples rather than its
    // reset value; WAIT_HIGH must not accept the reset-value 1 as "line high".
    logic [1:0] fill;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            fill  <= 2'b00;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
            rxs_d <= rxs;
            fill  <= {fill[0], 1'b1};
        end
    end

    logic fall, tick, maj;
    assign fall = rxs_d & ~rxs;
    assign tick = (cnt == CW'(DIV - 1));
    // Samples 7 and 8 are held; sample 9 is the live rxs on the deciding tick.
    assign maj  = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

`ifdef UART_RX_PARITY_EN
    logic par;
    logic par_bad;
    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign par_bad = (^shreg) ^ par;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= WAIT_HIGH;
            cnt       <= '0;
            smp       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            rx_ready  <= 1'b0;
            rx_data   <= 8'h00;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Free-running sample clock; re-phased to the start edge in IDLE.
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                smp <= smp + 4'd1;
                if (smp == 4'd7) s7 <= rxs;
                if (smp == 4'd8) s8 <= rxs;
            end

            case (state)
                WAIT_HIGH: begin
                    if (fill[1] && rxs) state <= IDLE;
                end
                IDLE: begin
                    if (fall) begin
                        cnt     <= '0;
                        smp     <= '0;
                        rx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick && smp == 4'd9 && maj) begin
                        rx_busy <= 1'b0;          // false start
                        state   <= IDLE;
                    end else if (tick && smp == 4'd15) begin
                        bitcnt <= '0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (tick && smp == 4'd9) shreg <= {maj, shreg[7:1]};
                    if (tick && smp == 4'd15) begin
                        bitcnt <= bitcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bitcnt == 3'd7) state <= PARITY;
`else
                        if (bitcnt == 3'd7) state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick && smp == 4'd9) par <= maj;
                    if (tick && smp == 4'd15) state <= STOP;
                end
`endif
                STOP: begin
                    // Decide at mid stop bit so back-to-back frames re-arm
                    // with half a stop bit of slack.
                    if (tick && smp == 4'd9) begin
                        rx_busy <= 1'b0;
                        if (maj) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                rx_data  <= shreg;
                                rx_ready <= 1'b1;
                            end
`else
                            rx_data  <= shreg;
                            rx_ready <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, expected strobes pushed into a
// scoreboard queue, a negedge monitor pops and compares each strobe.
module tb_uart_rx;

    localparam int CLK_HZ = 6_400_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = 4;
    localparam int BITC   = 16 * DIV;
    // rx is driven at the negedge following posedge P0; rxs falls at P0+2 (T0),
    // and the strobe register is visible from posedge T0 + N*DIV + 1.
`ifdef UART_RX_PARITY_EN
    localparam int NB   = 11;
    localparam int STRB = 2 + 170 * DIV + 1;
`else
    localparam int NB   = 10;
    localparam int STRB = 2 + 154 * DIV + 1;
`endif

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready, rx_busy, frame_err, parity_err;
    logic [7:0] rx_data;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;   // 0 ready, 1 frame_err, 2 parity_err
        logic [7:0] data;   // rx_data expected while the strobe is high
        int         at;     // expected cycle, -1 = not timed
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_strb = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [7:0] d, input int at);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.at   = at;
        q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic strb;
        strb = rx_ready | frame_err | parity_err;
        if (n_reset && strb) begin
            check("strobe one-hot", 32'(rx_ready) + 32'(frame_err) + 32'(parity_err), 1);
            check("strobe one cycle", 32'(prev_strb), 0);
            check("busy low at strobe", 32'(rx_busy), 0);
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected strobe: ready=%0b ferr=%0b perr=%0b data=%0h, expected none",
                         rx_ready, frame_err, parity_err, rx_data);
            end else begin
                exp_t e;
                int   k;
                e = q.pop_front();
                k = rx_ready ? 0 : (frame_err ? 1 : 2);
                check("strobe kind", 32'(k), 32'(e.kind));
                check("rx_data", 32'(rx_data), 32'(e.data));
                if (e.at >= 0) check("strobe cycle", 32'(cyc), 32'(e.at));
            end
        end
        prev_strb <= strb;
    end

    // Drives one frame, one rx value per clock; call at a negedge.
    // gl_at/gl_len invert rx for a window of clocks relative to the start.
    task automatic send(input logic [7:0] d, input int bitc, input logic stop,
                        input logic par_flip, input int gl_at, input int gl_len);
        logic [NB-1:0] fr;
        fr = '0;
        fr[0]   = 1'b0;
        fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
        fr[9] = (^d) ^ par_flip;
`endif
        fr[NB-1] = stop;
        for (int c = 0; c < NB * bitc; c++) begin
            rx = fr[c / bitc];
            if (c >= gl_at && c < gl_at + gl_len) rx = ~rx;
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int p0;
        // Reset state.
        repeat (3) @(negedge clk);
        check("reset rx_ready", 32'(rx_ready), 0);
        check("reset rx_data", 32'(rx_data), 0);
        check("reset rx_busy", 32'(rx_busy), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset parity_err", 32'(parity_err), 0);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);

        // Back-to-back 0x01 then 0x5A; busy drops only between frames.
        p0 = cyc;
        push_exp(0, 8'h01, p0 + STRB);
        push_exp(0, 8'h5A, p0 + NB * BITC + STRB);
        fork
            begin
                send(8'h01, BITC, 1'b1, 1'b0, -1, 0);
                send(8'h5A, BITC, 1'b1, 1'b0, -1, 0);
            end
            begin
                wait_cyc(p0 + 300);
                check("busy mid frame", 32'(rx_busy), 1);
                wait_cyc(p0 + STRB + 5);
                check("busy between frames", 32'(rx_busy), 0);
                wait_cyc(p0 + NB * BITC + 10);
                check("busy second frame", 32'(rx_busy), 1);
            end
        join
        last_good = 8'h5A;
        repeat (50) @(negedge clk);

        // 20-clock glitch: false start, busy falls at T0+10*DIV+1.
        p0 = cyc;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        wait_cyc(p0 + 2 + 10 * DIV);
        check("false start busy held", 32'(rx_busy), 1);
        wait_cyc(p0 + 2 + 10 * DIV + 1);
        check("false start busy drop", 32'(rx_busy), 0);
        repeat (100) @(negedge clk);

        // Line held low through the stop bit: frame_err, then WAIT_HIGH.
        p0 = cyc;
        push_exp(1, last_good, p0 + STRB);
        send(8'h00, BITC, 1'b0, 1'b0, -1, 0);
        rx = 1'b0;
        repeat (200) @(negedge clk);
        check("break: no new frame", 32'(rx_busy), 0);
        rx = 1'b1;
        repeat (50) @(negedge clk);

        // Re-armed after the line rose.
        p0 = cyc;
        push_exp(0, 8'hC3, p0 + STRB);
        send(8'hC3, BITC, 1'b1, 1'b0, -1, 0);
        last_good = 8'hC3;
        repeat (30) @(negedge clk);

        // 0xFF with a 4-clock low glitch over sample 8 of data bit 3.
        p0 = cyc;
        push_exp(0, 8'hFF, p0 + STRB);
        send(8'hFF, BITC, 1'b1, 1'b0, 4 * BITC + 8 * DIV + 4, 4);
        last_good = 8'hFF;
        repeat (30) @(negedge clk);

        // 0xA5 with the transmitter about 3% slow and 3% fast.
        push_exp(0, 8'hA5, -1);
        send(8'hA5, 66, 1'b1, 1'b0, -1, 0);
        repeat (30) @(negedge clk);
        push_exp(0, 8'hA5, -1);
        send(8'hA5, 62, 1'b1, 1'b0, -1, 0);
        last_good = 8'hA5;
        repeat (30) @(negedge clk);

        // Reset during data bit 4 of an all-zero frame, released with rx low.
        p0 = cyc;
        fork
            send(8'h00, BITC, 1'b1, 1'b0, -1, 0);
            begin
                wait_cyc(p0 + 2 + 5 * BITC + 20);
                check("busy before reset", 32'(rx_busy), 1);
                n_reset = 1'b0;
                @(negedge clk);
                check("mid reset rx_busy", 32'(rx_busy), 0);
                check("mid reset rx_data", 32'(rx_data), 0);
                check("mid reset rx_ready", 32'(rx_ready), 0);
                repeat (3) @(negedge clk);
                n_reset = 1'b1;
                repeat (10) @(negedge clk);
                check("after release busy", 32'(rx_busy), 0);
            end
        join
        last_good = 8'h00;
        repeat (50) @(negedge clk);
        p0 = cyc;
        push_exp(0, 8'h3C, p0 + STRB);
        send(8'h3C, BITC, 1'b1, 1'b0, -1, 0);
        last_good = 8'h3C;
        repeat (30) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 0x07 with correct parity, then with parity flipped.
        p0 = cyc;
        push_exp(0, 8'h07, p0 + STRB);
        send(8'h07, BITC, 1'b1, 1'b0, -1, 0);
        repeat (30) @(negedge clk);
        p0 = cyc;
        push_exp(2, 8'h07, p0 + STRB);
        send(8'h07, BITC, 1'b1, 1'b1, -1, 0);
        repeat (30) @(negedge clk);
`endif

        repeat (100) @(negedge clk);
        check("scoreboard drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500_000;
        errors++;
        $display("FAIL timeout: simulation reached cycle %0d, expected to finish earlier", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
